poly_mult_iter: RTL and testbench
=================================

Name: poly_mult_iter

Overview:
- Iterative schoolbook polynomial multiplier/squarer over redundant-coefficient operands, one b-coefficient row per cycle.
- Sequential carry-propagate normalisation pass follows the multiply; the output is in single-word form with an overflow flag.
- Successor to the fixed-mode single-shot multiplier:
  - runtime square/multiply select;
  - valid/ready handshake on both sides with output backpressure;
  - parametrised depth.
- Sits between the modular-squaring control loop and the reduction stage.

Parameters:
- WORD_BITS, 8, base radix bits per coefficient.
- REDUN_WORD_BITS, 1, redundant headroom bits per input coefficient.
- NUM_WORDS, 4, words in a fully reduced operand.
- I_WORD, NUM_WORDS+1, coefficients per input operand.
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, stored coefficient width.
- ACC_BITS (localparam), 2*COEF_BITS+$clog2(I_WORD)+1, accumulator coefficient width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_val  in  1  input transaction valid.
- o_rdy  out  1  block idle, able to accept.
- i_sq  in  1  1 = square (b := a, i_dat_b ignored), 0 = multiply.
- i_dat_a  in  I_WORD*COEF_BITS  operand a, packed [I_WORD-1:0][COEF_BITS-1:0].
- i_dat_b  in  I_WORD*COEF_BITS  operand b, same packing.
- o_val  out  1  result valid.
- i_rdy  in  1  downstream accepts result.
- o_dat  out  2*I_WORD*COEF_BITS  product, packed [2*I_WORD-1:0][COEF_BITS-1:0].
- o_ovf  out  1  top coefficient truncated.

Behaviour:
- One clock i_clk; reset i_rst is synchronous, active-high.
- Reset values:
  - o_rdy=1;
  - o_val=0, o_ovf=0;
  - o_dat=0;
  - accumulator cleared;
  - state IDLE.
- States IDLE, MULT, NORM, DONE. o_rdy = (state==IDLE).
- IDLE:
  - on i_val&o_rdy at edge E0, latch a, latch b (a if i_sq), clear accumulator, row counter j=0, go MULT.
  - i_val ignored in every other state; no input is queued.
- MULT:
  - each edge adds a[i]*b[j] into acc[i+j] for all i, then j++.
  - after row j=I_WORD-1 (edge E_I_WORD), go NORM with k=0, carry=0.
- NORM:
  - per edge: t = acc[k]+carry; o_dat[k] = t[WORD_BITS-1:0]; carry = t>>WORD_BITS; k++.
  - the top coefficient k=2*I_WORD-1 stores t[COEF_BITS-1:0].
  - o_ovf = |(t>>COEF_BITS) for the top coefficient.
  - after k=2*I_WORD-1 (edge E_3*I_WORD), go DONE.
- DONE:
  - o_val=1; o_dat and o_ovf held stable until i_rdy.
  - on i_rdy edge: o_val=0, go IDLE.
  - o_dat retains its value after the handoff until the next NORM pass writes it.
- Latency: o_val first high in the cycle after edge E_3*I_WORD, i.e. 3*I_WORD cycles after the accept cycle (15 for I_WORD=5).
- Throughput: one transaction per 3*I_WORD+2 cycles when i_rdy=1.
- Arithmetic:
  - inputs may carry any COEF_BITS value (redundant form).
  - outputs 0..2*I_WORD-2 are always < 2^WORD_BITS.
  - sum over k of o_dat[k]*2^(k*WORD_BITS) equals A*B exactly when o_ovf=0, and equals A*B mod 2^((2*I_WORD-1)*WORD_BITS+COEF_BITS) otherwise.
  - the accumulator must never wrap, which ACC_BITS guarantees.
- i_sq is sampled only at accept; changing it mid-operation has no effect.
- Reset mid-operation (any state): the next cycle shows IDLE, o_rdy=1, o_val=0, o_ovf=0, o_dat=0; the partial result is discarded.
- Reset overrides a simultaneous accept or handoff.

Test Plan:
- Square, a=2 (o_dat[0]=2, rest 0), i_sq=1, i_dat_b=0x1FF garbage:
  - o_val at cycle 15 after accept, o_dat[0]=4, all other coefficients 0, o_ovf=0.
- Squaring chain, feeding o_dat back as a, with I_WORD=5, WORD_BITS=8:
  - 2 → 4 → 16 → 256 → 65536 → 2^32 → 2^64.
  - each result matches, o_ovf=0; stop when the expected value is ≥2^80.
- Multiply, redundant input: a all coefficients 0x1FF, b=1, i_sq=0:
  - o_dat value = 511*(256^5-1)/255.
  - coefficients 0..8 < 256, o_ovf=0.
- Overflow: a=b all coefficients 0x1FF, i_sq=1:
  - o_ovf=1.
  - coefficients 0..8 < 256.
  - value = A^2 mod 2^81.
- Backpressure and busy:
  - hold i_rdy=0 for 10 cycles after o_val: o_val, o_dat and o_ovf stay stable.
  - pulse i_val during MULT/NORM: o_rdy=0 and no second result is produced.
  - raise i_rdy: o_val falls next cycle, o_rdy=1.
- Reset mid-MULT, then clean transaction:
  - multiply a=3, b=7; assert i_rst for 1 cycle at cycle 3 after accept.
  - next cycle: o_rdy=1, o_val=0, o_dat=0.
  - a fresh transaction a=3, b=7 yields o_dat[0]=21 at cycle 15.

Source files
------------

// File: rtl/poly_mult_iter.sv
// Iterative schoolbook polynomial multiplier/squarer: one b-row per cycle into a
// wide accumulator, then a sequential carry-propagate pass into single-word form.
module poly_mult_iter #(
  parameter int WORD_BITS       = 8,
  parameter int REDUN_WORD_BITS = 1,
  parameter int NUM_WORDS       = 4,
  parameter int I_WORD          = NUM_WORDS + 1,
  parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_val,
  output logic                                    o_rdy,
  input  logic                                    i_sq,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]        i_dat_a,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]        i_dat_b,
  output logic                                    o_val,
  input  logic                                    i_rdy,
  output logic [2*I_WORD-1:0][COEF_BITS-1:0]      o_dat,
  output logic                                    o_ovf
);

  localparam int ACC_BITS = 2*COEF_BITS + $clog2(I_WORD) + 1;
  localparam int NCOEF    = 2*I_WORD;
  localparam int CNT_W    = $clog2(NCOEF);
  localparam int T_BITS   = ACC_BITS + 1;
  localparam int CARRY_W  = T_BITS - WORD_BITS;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  state_t                              state_q, state_d;
  logic [I_WORD-1:0][COEF_BITS-1:0]    a_q, a_d;
  logic [I_WORD-1:0][COEF_BITS-1:0]    b_q, b_d;
  logic [NCOEF-1:0][ACC_BITS-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [CARRY_W-1:0]                  carry_q, carry_d;
  logic [NCOEF-1:0][COEF_BITS-1:0]     dat_q, dat_d;
  logic                                ovf_q, ovf_d;
  logic [T_BITS-1:0]                   t;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    dat_d   = dat_q;
    ovf_d   = ovf_q;
    t       = T_BITS'(acc_q[cnt_q]) + T_BITS'(carry_q);

    unique case (state_q)
      IDLE: begin
        if (i_val) begin
          a_d     = i_dat_a;
          b_d     = i_sq ? i_dat_a : i_dat_b;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = '0;
          ovf_d   = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        // b is shifted down each row so the current row coefficient is always b_q[0]
        for (int unsigned i = 0; i < I_WORD; i++) begin
          acc_d[CNT_W'(i) + cnt_q] = acc_q[CNT_W'(i) + cnt_q]
                                   + ACC_BITS'(a_q[i]) * ACC_BITS'(b_q[0]);
        end
        b_d = b_q >> COEF_BITS;
        if (cnt_q == CNT_W'(I_WORD-1)) begin
          cnt_d   = '0;
          carry_d = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NORM: begin
        carry_d = t[T_BITS-1:WORD_BITS];
        if (cnt_q == CNT_W'(NCOEF-1)) begin
          dat_d[cnt_q] = t[COEF_BITS-1:0];
          ovf_d        = |t[T_BITS-1:COEF_BITS];
          cnt_d        = '0;
          state_d      = DONE;
        end else begin
          dat_d[cnt_q] = COEF_BITS'(t[WORD_BITS-1:0]);
          cnt_d        = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_rdy = (state_q == IDLE);
  assign o_val = (state_q == DONE);
  assign o_dat = dat_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_poly_mult_iter.sv
// Self-checking bench for poly_mult_iter against an integer-arithmetic product model.
module tb_poly_mult_iter;

  localparam int W  = 8;
  localparam int C  = 9;
  localparam int IW = 5;
  localparam int NC = 2*IW;

  typedef logic [IW-1:0][C-1:0] opnd_t;
  typedef logic [NC-1:0][C-1:0] res_t;

  logic  i_clk = 1'b0;
  logic  i_rst = 1'b1;
  logic  i_val = 1'b0;
  logic  o_rdy;
  logic  i_sq  = 1'b0;
  opnd_t i_dat_a = '0;
  opnd_t i_dat_b = '0;
  logic  o_val;
  logic  i_rdy = 1'b0;
  res_t  o_dat;
  logic  o_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  poly_mult_iter #(
    .WORD_BITS(W),
    .REDUN_WORD_BITS(1),
    .NUM_WORDS(4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_sq(i_sq),
    .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .o_val(o_val), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model: plain integer arithmetic ----
  function automatic logic [255:0] opval(input opnd_t x);
    logic [255:0] v = '0;
    for (int i = 0; i < IW; i++) v = v + (256'(x[i]) << (W*i));
    return v;
  endfunction

  function automatic res_t exp_coefs(input logic [255:0] p);
    res_t r;
    logic [255:0] s;
    for (int k = 0; k < NC-1; k++) begin
      s = (p >> (W*k)) & 256'hFF;
      r[k] = s[C-1:0];
    end
    s = (p >> (W*(NC-1))) & 256'h1FF;
    r[NC-1] = s[C-1:0];
    return r;
  endfunction

  function automatic logic exp_ovf(input logic [255:0] p);
    return (p >> ((NC-1)*W + C)) != 0;
  endfunction

  function automatic opnd_t opnd_from(input logic [255:0] v);
    opnd_t x;
    logic [255:0] s;
    for (int i = 0; i < IW; i++) begin
      s = (v >> (W*i)) & 256'hFF;
      x[i] = s[C-1:0];
    end
    return x;
  endfunction

  function automatic opnd_t rnd_opnd();
    opnd_t x;
    for (int i = 0; i < IW; i++) x[i] = C'($urandom_range(0, 511));
    return x;
  endfunction

  // ---- stimulus driver (no checking of results; returns what it observed) ----
  task automatic run_txn(input opnd_t a, input opnd_t b, input bit sq, input int hold,
                         output res_t dat, output bit ovf, output int lat, output int acc_cyc);
    int n = 0;
    while (!o_rdy && n < 100) begin @(negedge i_clk); n++; end
    if (!o_rdy) begin
      total++; bad++;
      $display("FAIL rdy_timeout: o_rdy=%0b required 1", o_rdy);
    end
    i_val   = 1'b1;
    i_sq    = sq;
    i_dat_a = a;
    i_dat_b = sq ? rnd_opnd() : b;
    acc_cyc = cyc;
    @(negedge i_clk);
    i_val   = 1'b0;
    i_sq    = 1'($urandom_range(0, 1));
    i_dat_a = rnd_opnd();
    i_dat_b = rnd_opnd();
    lat = 0;
    while (!o_val && lat < 100) begin @(negedge i_clk); lat++; end
    if (!o_val) begin
      total++; bad++;
      $display("FAIL val_timeout: o_val=%0b required 1", o_val);
    end
    dat = o_dat;
    ovf = o_ovf;
    repeat (hold) @(negedge i_clk);
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    total++;
    if (o_rdy !== 1'b1 || o_val !== 1'b0 || o_ovf !== 1'b0 || o_dat !== res_t'(0)) begin
      bad++;
      $display("FAIL reset: rdy=%0b val=%0b ovf=%0b dat=%h required 1 0 0 0",
               o_rdy, o_val, o_ovf, o_dat);
    end
  endtask

  task automatic test_square_two();
    opnd_t a = '0, b;
    res_t dat, e;
    bit ovf;
    int lat, ac;
    a[0] = 9'd2;
    for (int i = 0; i < IW; i++) b[i] = 9'h1FF;
    run_txn(a, b, 1'b1, 0, dat, ovf, lat, ac);
    e = exp_coefs(opval(a) * opval(a));
    total++;
    if (lat !== 15) begin bad++; $display("FAIL sq2_latency: got %0d required 15", lat); end
    total++;
    if (dat !== e || dat[0] !== 9'd4) begin bad++; $display("FAIL sq2_data: got %h required %h", dat, e); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL sq2_ovf: got %0b required 0", ovf); end
  endtask

  task automatic test_square_chain();
    logic [255:0] v = 256'd2, p;
    res_t dat;
    bit ovf;
    int lat, ac;
    p = v * v;
    while (p < (256'd1 << 80)) begin
      run_txn(opnd_from(v), '0, 1'b1, 0, dat, ovf, lat, ac);
      total++;
      if (dat !== exp_coefs(p) || ovf !== 1'b0) begin
        bad++;
        $display("FAIL chain_%0h: got %h ovf=%0b required %h ovf=0", v, dat, ovf, exp_coefs(p));
      end
      v = p;
      p = v * v;
    end
  endtask

  task automatic test_redundant_mult();
    opnd_t a, b = '0;
    res_t dat;
    bit ovf;
    int lat, ac;
    logic [255:0] p;
    for (int i = 0; i < IW; i++) a[i] = 9'h1FF;
    b[0] = 9'd1;
    p = 256'd511 * ((256'd1 << 40) - 1) / 255;
    run_txn(a, b, 1'b0, 0, dat, ovf, lat, ac);
    total++;
    if (dat !== exp_coefs(p) || ovf !== 1'b0) begin
      bad++;
      $display("FAIL redundant_mult: got %h ovf=%0b required %h ovf=0", dat, ovf, exp_coefs(p));
    end
  endtask

  task automatic test_overflow();
    opnd_t a;
    res_t dat;
    bit ovf;
    int lat, ac;
    logic [255:0] p;
    for (int i = 0; i < IW; i++) a[i] = 9'h1FF;
    p = opval(a) * opval(a);
    run_txn(a, '0, 1'b1, 3, dat, ovf, lat, ac);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL overflow_flag: got %0b required 1", ovf); end
    total++;
    if (dat !== exp_coefs(p)) begin bad++; $display("FAIL overflow_data: got %h required %h", dat, exp_coefs(p)); end
  endtask

  task automatic test_random();
    opnd_t a, b;
    res_t dat;
    bit ovf, sq;
    int lat, ac;
    logic [255:0] p;
    for (int n = 0; n < 20; n++) begin
      a  = rnd_opnd();
      b  = rnd_opnd();
      sq = 1'($urandom_range(0, 1));
      if (n % 4 == 0) a[IW-1] = '0;
      p = opval(a) * (sq ? opval(a) : opval(b));
      run_txn(a, b, sq, $urandom_range(0, 4), dat, ovf, lat, ac);
      total++;
      if (dat !== exp_coefs(p) || ovf !== exp_ovf(p) || lat !== 15) begin
        bad++;
        $display("FAIL random_%0d: got %h ovf=%0b lat=%0d required %h ovf=%0b lat=15",
                 n, dat, ovf, lat, exp_coefs(p), exp_ovf(p));
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t dat;
    bit ovf;
    int lat, c0, c1;
    opnd_t a = rnd_opnd(), b = rnd_opnd();
    run_txn(a, b, 1'b0, 0, dat, ovf, lat, c0);
    run_txn(b, a, 1'b0, 0, dat, ovf, lat, c1);
    total++;
    if (c1 - c0 !== 17) begin bad++; $display("FAIL back_to_back_period: got %0d required 17", c1 - c0); end
    total++;
    if (dat !== exp_coefs(opval(a) * opval(b))) begin
      bad++;
      $display("FAIL back_to_back_data: got %h required %h", dat, exp_coefs(opval(a) * opval(b)));
    end
  endtask

  task automatic test_backpressure();
    opnd_t a = rnd_opnd(), b = rnd_opnd();
    res_t snap, e;
    bit snap_ovf;
    int n = 0;
    e = exp_coefs(opval(a) * opval(b));
    i_val = 1'b1; i_sq = 1'b0; i_dat_a = a; i_dat_b = b;
    @(negedge i_clk);
    i_val = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      if (k == 2 || k == 8) begin
        total++;
        if (o_rdy !== 1'b0) begin bad++; $display("FAIL busy_rdy_%0d: got %0b required 0", k, o_rdy); end
        i_val = 1'b1; i_dat_a = rnd_opnd(); i_dat_b = rnd_opnd();
      end else begin
        i_val = 1'b0;
      end
    end
    i_val = 1'b0;
    while (!o_val && n < 100) begin @(negedge i_clk); n++; end
    snap = o_dat; snap_ovf = o_ovf;
    total++;
    if (snap !== e || o_val !== 1'b1) begin
      bad++;
      $display("FAIL bp_data: got %h val=%0b required %h val=1", snap, o_val, e);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      total++;
      if (o_val !== 1'b1 || o_dat !== snap || o_ovf !== snap_ovf) begin
        bad++;
        $display("FAIL bp_hold_%0d: val=%0b dat=%h required val=1 dat=%h", k, o_val, o_dat, snap);
      end
    end
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
    total++;
    if (o_val !== 1'b0 || o_rdy !== 1'b1 || o_dat !== snap) begin
      bad++;
      $display("FAIL bp_handoff: val=%0b rdy=%0b dat=%h required 0 1 %h", o_val, o_rdy, o_dat, snap);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      total++;
      if (o_val !== 1'b0) begin bad++; $display("FAIL bp_no_second_%0d: val=%0b required 0", k, o_val); end
    end
  endtask

  task automatic test_reset_mid();
    opnd_t a = '0, b = '0;
    res_t dat;
    bit ovf;
    int lat, ac;
    a[0] = 9'd3; b[0] = 9'd7;
    i_val = 1'b1; i_sq = 1'b0; i_dat_a = a; i_dat_b = b;
    @(negedge i_clk);
    i_val = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    total++;
    if (o_rdy !== 1'b1 || o_val !== 1'b0 || o_ovf !== 1'b0 || o_dat !== res_t'(0)) begin
      bad++;
      $display("FAIL mid_reset: rdy=%0b val=%0b ovf=%0b dat=%h required 1 0 0 0",
               o_rdy, o_val, o_ovf, o_dat);
    end
    run_txn(a, b, 1'b0, 0, dat, ovf, lat, ac);
    total++;
    if (dat !== exp_coefs(256'd21) || lat !== 15 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_txn: got %h lat=%0d ovf=%0b required %h lat=15 ovf=0",
               dat, lat, ovf, exp_coefs(256'd21));
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_square_two();
    test_square_chain();
    test_redundant_mult();
    test_overflow();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
